// File: rtl/skidbuf_pkg.sv
// Shared generic-library package: skid buffer occupancy states.
package skidbuf_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/skidbuf_if.sv
// Valid/ready handshake bundle for both sides of the skid buffer.
interface skidbuf_if #(
  parameter int unsigned WIDTH = 8
);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] InData;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] OutData;

  modport master (
    output InValid, InData, OutReady,
    input  InReady, OutValid, OutData
  );

  modport slave (
    input  InValid, InData, OutReady,
    output InReady, OutValid, OutData
  );
endinterface

// File: rtl/skidbuf_entry.sv
// Enabled data register with synchronous clear; one storage slot of the skid buffer.
module skidbuf_entry #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/skidbuf.sv
// Two-entry skid buffer: registered ready/valid on both sides, one transfer per cycle.
module skidbuf
  import skidbuf_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic       clk,
  input logic       reset,
  input logic       Flush,
  skidbuf_if.slave  bus
);

  skid_state_e      state_q, state_d;
  logic             in_ready, out_valid, in_fire, out_fire;
  logic             main_load, skid_load, main_from_skid;
  logic [WIDTH-1:0] main_q, skid_q, main_d;

  // Handshake outputs depend only on registered state.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = bus.InValid & in_ready;
  assign out_fire  = out_valid & bus.OutReady;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (Flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_d = main_from_skid ? skid_q : bus.InData;

  skidbuf_entry #(.WIDTH(WIDTH)) u_main (
    .clk    (clk),
    .reset  (reset),
    .load_i (main_load),
    .data_i (main_d),
    .data_o (main_q)
  );

  skidbuf_entry #(.WIDTH(WIDTH)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .load_i (skid_load),
    .data_i (bus.InData),
    .data_o (skid_q)
  );

  assign bus.InReady  = in_ready;
  assign bus.OutValid = out_valid;
  assign bus.OutData  = main_q;

endmodule

// File: tb/tb_skidbuf.sv
// Self-checking bench for skidbuf: directed scenarios plus randomized handshakes vs a queue model.
module tb_skidbuf;
  import skidbuf_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic Flush;

  skidbuf_if #(.WIDTH(8)) bus ();

  skidbuf #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .Flush (Flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  model_q[$];

  assert property (@(posedge clk) !(dut.state_q == TWO && bus.InValid && bus.InReady))
    else $error("InFire while buffer full");

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock: update the queue model from the inputs presented, then compare outputs.
  task automatic cycle();
    bit         in_fire, out_fire, stall;
    logic [7:0] held;
    stall    = bus.OutValid && !bus.OutReady && !reset && !Flush;
    held     = bus.OutData;
    in_fire  = bus.InValid && (model_q.size() < 2);
    out_fire = bus.OutReady && (model_q.size() > 0);
    @(posedge clk);
    if (reset || Flush) begin
      model_q.delete();
    end else begin
      if (out_fire) void'(model_q.pop_front());
      if (in_fire) model_q.push_back(bus.InData);
    end
    @(negedge clk);
    check_eq("in_ready", 32'(bus.InReady), 32'(model_q.size() < 2));
    check_eq("out_valid", 32'(bus.OutValid), 32'(model_q.size() > 0));
    if (model_q.size() > 0) check_eq("out_data", 32'(bus.OutData), 32'(model_q[0]));
    if (stall) begin
      check_eq("stall_valid", 32'(bus.OutValid), 32'd1);
      check_eq("stall_data", 32'(bus.OutData), 32'(held));
    end
  endtask

  task automatic drain();
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b1;
    repeat (3) cycle();
  endtask

  initial begin
    reset        = 1'b1;
    Flush        = 1'b0;
    bus.InValid  = 1'b1;
    bus.InData   = 8'hAA;
    bus.OutReady = 1'b0;
    @(negedge clk);

    // Reset held two cycles with a word on offer
    repeat (2) begin
      cycle();
      check_eq("rst_out_valid", 32'(bus.OutValid), 32'd0);
      check_eq("rst_in_ready", 32'(bus.InReady), 32'd1);
      check_eq("rst_out_data", 32'(bus.OutData), 32'h00);
    end
    reset = 1'b0;
    check_eq("rst_drop_out_valid", 32'(bus.OutValid), 32'd0);
    check_eq("rst_drop_out_data", 32'(bus.OutData), 32'h00);
    cycle();
    check_eq("first_accept", 32'(bus.OutData), 32'hAA);
    drain();

    // Streaming at full rate
    bus.OutReady = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.InValid = 1'b1;
      bus.InData  = 8'(i);
      cycle();
      check_eq("stream_data", 32'(bus.OutData), 32'(i));
      check_eq("stream_ready", 32'(bus.InReady), 32'd1);
    end
    drain();

    // Backpressure: skid absorbs one word, third is held by producer
    bus.OutReady = 1'b0;
    bus.InValid  = 1'b1;
    bus.InData   = 8'h11;
    cycle();
    bus.InData   = 8'h22;
    cycle();
    check_eq("bp_ready_low", 32'(bus.InReady), 32'd0);
    bus.InData   = 8'h33;
    cycle();
    check_eq("bp_head_held", 32'(bus.OutData), 32'h11);
    bus.OutReady = 1'b1;
    cycle();
    check_eq("bp_order_2", 32'(bus.OutData), 32'h22);
    cycle();
    check_eq("bp_order_3", 32'(bus.OutData), 32'h33);
    bus.InValid = 1'b0;
    cycle();
    check_eq("bp_empty", 32'(bus.OutValid), 32'd0);
    drain();

    // Randomized valid/ready against the queue model
    for (int i = 0; i < 1000; i++) begin
      bus.InValid  = 1'($urandom_range(0, 1));
      bus.InData   = 8'($urandom);
      bus.OutReady = 1'($urandom_range(0, 3) != 0 ? i % 7 != 0 : 0);
      cycle();
    end
    drain();

    // Flush while full, with a simultaneous offer
    bus.OutReady = 1'b0;
    bus.InValid  = 1'b1;
    bus.InData   = 8'h44;
    cycle();
    bus.InData   = 8'h55;
    cycle();
    Flush       = 1'b1;
    bus.InData  = 8'h66;
    cycle();
    check_eq("flush_out_valid", 32'(bus.OutValid), 32'd0);
    check_eq("flush_in_ready", 32'(bus.InReady), 32'd1);
    Flush        = 1'b0;
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b1;
    repeat (3) begin
      cycle();
      check_eq("flush_stays_empty", 32'(bus.OutValid), 32'd0);
    end

    // Reset during an output transfer in ONE
    bus.InValid = 1'b1;
    bus.InData  = 8'h5A;
    cycle();
    bus.InValid = 1'b0;
    reset       = 1'b1;
    cycle();
    check_eq("mrst_out_valid", 32'(bus.OutValid), 32'd0);
    check_eq("mrst_out_data", 32'(bus.OutData), 32'h00);
    reset       = 1'b0;
    bus.InValid = 1'b1;
    bus.InData  = 8'h77;
    cycle();
    check_eq("mrst_push", 32'(bus.OutData), 32'h77);
    bus.InValid = 1'b0;
    cycle();
    check_eq("mrst_alone", 32'(bus.OutValid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
